// File: rtl/des_pkg.sv
// Shared DES constants: block/half widths, IP and FP bit tables (FIPS-46 numbering,
// entry 0 = output bit 1 = MSB), and the unload FSM state type.
package des_pkg;

   localparam int DES_BLK_W  = 64;
   localparam int DES_HALF_W = 32;

   localparam logic [6:0] IP_TABLE [DES_BLK_W] = '{
      7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
      7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
      7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
      7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
      7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
      7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
      7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
      7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
   };

   localparam logic [6:0] FP_TABLE [DES_BLK_W] = '{
      7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
      7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
      7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
      7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
      7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
      7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
      7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
      7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
   };

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } unload_state_t;

endpackage

// File: rtl/des_fp.sv
// Final permutation (IP^-1), pure wiring: output bit n (1 = MSB) takes input bit FP_TABLE[n-1].
// Zero latency, no flow control; shared with the decrypt path.
module des_fp
   import des_pkg::*;
(
   input  logic [DES_BLK_W-1:0] din,
   output logic [DES_BLK_W-1:0] dout
);

   for (genvar i = 0; i < DES_BLK_W; i++) begin : g_bit
      assign dout[DES_BLK_W-1-i] = din[DES_BLK_W - int'(FP_TABLE[i])];
   end

endmodule

// File: rtl/des_fp_unload.sv
// DES output stage: swap + FP, registers the ciphertext, then streams it MSB-first in
// SERIAL_W beats; first beat valid the cycle after accept, beats hold while out_ready is low.
module des_fp_unload
   import des_pkg::*;
#(
   parameter int SERIAL_W = 8,
   parameter bit SWAP     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DES_HALF_W-1:0] l16,
   input  logic [DES_HALF_W-1:0] r16,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SERIAL_W-1:0]   out_data,
   output logic                  out_last,
   output logic [DES_BLK_W-1:0]  block_q,
   output logic                  blk_done
);

   localparam int BEATS = DES_BLK_W / SERIAL_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   unload_state_t        state_q, state_d;
   logic [DES_BLK_W-1:0] shreg_q, shreg_d;
   logic [DES_BLK_W-1:0] block_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                 blk_done_q, blk_done_d;

   logic [DES_BLK_W-1:0] pre_fp;
   logic [DES_BLK_W-1:0] fp_out;

   assign pre_fp = SWAP ? {r16, l16} : {l16, r16};

   des_fp u_fp (
      .din  (pre_fp),
      .dout (fp_out)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      block_d    = block_q;
      beat_cnt_d = beat_cnt_q;
      blk_done_d = 1'b0;

      // Handshake outputs depend on state only, so out_ready never reaches in_ready.
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_SEND);
      out_data  = out_valid ? shreg_q[DES_BLK_W-1 -: SERIAL_W] : '0;
      out_last  = out_valid && (beat_cnt_q == LAST_BEAT);

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d    = ST_SEND;
               block_d    = fp_out;
               shreg_d    = fp_out;
               beat_cnt_d = '0;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               shreg_d = shreg_q << SERIAL_W;
               if (out_last) begin
                  state_d    = ST_IDLE;
                  blk_done_d = 1'b1;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         block_q    <= '0;
         beat_cnt_q <= '0;
         blk_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         block_q    <= block_d;
         beat_cnt_q <= beat_cnt_d;
         blk_done_q <= blk_done_d;
      end
   end

   assign blk_done = blk_done_q;

endmodule

// File: tb/tb_des_fp_unload.sv
// Directed bench for des_fp_unload: KAT, backpressure, reset mid-stream, back-to-back,
// width sweep (16/64) and the FP(IP(x)) == x property on a SWAP=0 instance.
module tb_des_fp_unload;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Main instance: SERIAL_W = 8, SWAP = 1
   logic        in_valid, in_ready, out_valid, out_ready, out_last, blk_done;
   logic [31:0] l16, r16;
   logic [7:0]  out_data;
   logic [63:0] block_q;

   // Secondary group sharing one input port set
   logic        in_valid2;
   logic [31:0] l16_2, r16_2;
   logic        out_ready2;
   logic        w16_in_ready, w16_out_valid, w16_out_last, w16_blk_done;
   logic [15:0] w16_out_data;
   logic [63:0] w16_block_q;
   logic        w64_in_ready, w64_out_valid, w64_out_last, w64_blk_done;
   logic [63:0] w64_out_data, w64_block_q;
   logic        inv_in_ready, inv_out_valid, inv_out_last, inv_blk_done;
   logic [63:0] inv_out_data, inv_block_q;

   des_fp_unload #(.SERIAL_W(8), .SWAP(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .l16(l16), .r16(r16), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .block_q(block_q), .blk_done(blk_done)
   );

   des_fp_unload #(.SERIAL_W(16), .SWAP(1'b1)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(w16_in_ready),
      .l16(l16_2), .r16(r16_2), .out_valid(w16_out_valid), .out_ready(out_ready2),
      .out_data(w16_out_data), .out_last(w16_out_last), .block_q(w16_block_q),
      .blk_done(w16_blk_done)
   );

   des_fp_unload #(.SERIAL_W(64), .SWAP(1'b1)) u_w64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(w64_in_ready),
      .l16(l16_2), .r16(r16_2), .out_valid(w64_out_valid), .out_ready(out_ready2),
      .out_data(w64_out_data), .out_last(w64_out_last), .block_q(w64_block_q),
      .blk_done(w64_blk_done)
   );

   des_fp_unload #(.SERIAL_W(64), .SWAP(1'b0)) u_inv (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(inv_in_ready),
      .l16(l16_2), .r16(r16_2), .out_valid(inv_out_valid), .out_ready(out_ready2),
      .out_data(inv_out_data), .out_last(inv_out_last), .block_q(inv_block_q),
      .blk_done(inv_blk_done)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] kat_l  = 32'h43423234;
   logic [31:0] kat_r  = 32'h0A4CD995;
   logic [63:0] kat_ct = 64'h85E813540F0AB405;
   logic [63:0] ones_ct = 64'hAAAAAAAAAAAAAAAA;  // FP of {0, FFFFFFFF}

   int ip_tab [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
   };

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      logic [5:0]  src;
      logic [5:0]  dst;
      y = '0;
      for (int n = 0; n < 64; n++) begin
         src = 6'(64 - ip_tab[n]);
         dst = 6'(63 - n);
         y[dst] = x[src];
      end
      return y;
   endfunction

   // Drains one 8-beat block on the main instance, starting in the first SEND cycle.
   task automatic drain8(input string tag, input logic [63:0] exp, input int stall_at,
                         input int stall_len);
      logic [7:0] beat;
      for (int b = 0; b < 8; b++) begin
         beat = exp[63 - 8*b -: 8];
         if (b == 0) check_val({tag, "_nodone0"}, 64'(blk_done), 64'd0);
         if (b == stall_at) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            l16       = 32'hDEADBEEF;
            for (int s = 0; s < stall_len; s++) begin
               tick;
               check_val({tag, "_stall_dat"}, 64'(out_data), 64'(beat));
               check_val({tag, "_stall_vld"}, 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            l16       = kat_l;
         end
         check_val({tag, "_vld"}, 64'(out_valid), 64'd1);
         check_val({tag, "_dat"}, 64'(out_data), 64'(beat));
         check_val({tag, "_last"}, 64'(out_last), (b == 7) ? 64'd1 : 64'd0);
         check_val({tag, "_inrdy_lo"}, 64'(in_ready), 64'd0);
         tick;
      end
      check_val({tag, "_done"}, 64'(blk_done), 64'd1);
      check_val({tag, "_inrdy_hi"}, 64'(in_ready), 64'd1);
      check_val({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] x;
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; l16 = '0; r16 = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; l16_2 = '0; r16_2 = '0;
      tick;
      tick;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_data", 64'(out_data), 64'd0);
      check_val("rst_out_last", 64'(out_last), 64'd0);
      check_val("rst_block_q", block_q, 64'd0);
      check_val("rst_blk_done", 64'(blk_done), 64'd0);
      rst_n = 1'b1;
      tick;

      // Known-answer block, no stalls
      l16 = kat_l; r16 = kat_r; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      check_val("kat_block_q", block_q, kat_ct);
      drain8("kat", kat_ct, -1, 0);
      tick;
      check_val("kat_done_pulse", 64'(blk_done), 64'd0);
      check_val("kat_block_persist", block_q, kat_ct);

      // Backpressure at beat 3 with a competing in_valid
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      drain8("bp", kat_ct, 3, 5);
      check_val("bp_block_q", block_q, kat_ct);
      tick;

      // Reset after two beats have been handed off
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      check_val("mid_beat2", 64'(out_data), 64'h13);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check_val("mid_out_valid", 64'(out_valid), 64'd0);
      check_val("mid_blk_done", 64'(blk_done), 64'd0);
      check_val("mid_block_q", block_q, 64'd0);
      check_val("mid_in_ready", 64'(in_ready), 64'd1);
      tick;
      check_val("mid_blk_done2", 64'(blk_done), 64'd0);
      check_val("mid_out_valid2", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      check_val("mid_new_block", block_q, kat_ct);
      drain8("mid_new", kat_ct, -1, 0);
      tick;

      // Back-to-back: second block waits with in_valid high
      l16 = kat_l; r16 = kat_r; in_valid = 1'b1;
      tick;
      l16 = 32'hFFFFFFFF; r16 = 32'h0;
      for (int b = 0; b < 8; b++) begin
         check_val("b2b_first_dat", 64'(out_data), 64'(kat_ct[63 - 8*b -: 8]));
         check_val("b2b_first_last", 64'(out_last), (b == 7) ? 64'd1 : 64'd0);
         tick;
      end
      check_val("b2b_idle_inrdy", 64'(in_ready), 64'd1);
      check_val("b2b_idle_vld", 64'(out_valid), 64'd0);
      check_val("b2b_first_done", 64'(blk_done), 64'd1);
      check_val("b2b_first_block", block_q, kat_ct);
      tick;
      in_valid = 1'b0;
      check_val("b2b_second_block", block_q, ones_ct);
      drain8("b2b", ones_ct, -1, 0);
      l16 = kat_l; r16 = kat_r;
      tick;

      // Width sweep on the KAT vector
      l16_2 = kat_l; r16_2 = kat_r; in_valid2 = 1'b1;
      tick;
      in_valid2 = 1'b0;
      check_val("w64_vld", 64'(w64_out_valid), 64'd1);
      check_val("w64_dat", w64_out_data, kat_ct);
      check_val("w64_last", 64'(w64_out_last), 64'd1);
      for (int b = 0; b < 4; b++) begin
         check_val("w16_dat", 64'(w16_out_data), 64'(kat_ct[63 - 16*b -: 16]));
         check_val("w16_last", 64'(w16_out_last), (b == 3) ? 64'd1 : 64'd0);
         if (b == 1) begin
            check_val("w64_done", 64'(w64_blk_done), 64'd1);
            check_val("w64_inrdy", 64'(w64_in_ready), 64'd1);
         end
         tick;
      end
      check_val("w16_done", 64'(w16_blk_done), 64'd1);
      check_val("w16_block_q", w16_block_q, kat_ct);
      tick;

      // FP is the inverse of IP
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom(), $urandom()};
         {l16_2, r16_2} = ip_perm(x);
         in_valid2 = 1'b1;
         tick;
         in_valid2 = 1'b0;
         check_val("inv_fp_ip", inv_block_q, x);
         tick;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
